// File: rtl/mem_stage_lsu_if.sv
// AXI4-Lite-style data-bus bundle between the MEM-stage LSU (master) and data memory (slave).
interface mem_stage_lsu_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int WMASK_LENGTH = 4
);
    logic [DATA_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata_o;
    logic [WMASK_LENGTH-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata_o, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata_o, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one data-bus transaction per instruction, extended load data out,
// and Mready back-pressure into EX/MEM while an access is outstanding.
module mem_stage_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int WMASK_LENGTH   = 4,
    parameter int ROPCODE_LENGTH = 3
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [WMASK_LENGTH-1:0]   wmask,
    input  logic [ROPCODE_LENGTH-1:0] ropcode,
    input  logic [DATA_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    mem_stage_lsu_if.master           bus,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_rdata,
    output logic                      out_err
);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    // Load size decode; 011 and 11x fall through to word.
    logic ld_byte, ld_half, ld_word, ld_signed;
    assign ld_byte   = (ropcode[1:0] == 2'b00);
    assign ld_half   = (ropcode[1:0] == 2'b01);
    assign ld_word   = ~ld_byte & ~ld_half;
    assign ld_signed = ~ropcode[2];

    logic misaligned;
    assign misaligned =
        (mem_read  & ((ld_half & addr[0]) | (ld_word & (addr[1:0] != 2'b00)))) |
        (mem_write & (((wmask == 4'b0011) & addr[0]) |
                      ((wmask == 4'b1111) & (addr[1:0] != 2'b00))));

    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_data;
    assign rd_byte = bus.rdata[{addr[1:0], 3'b000} +: 8];
    assign rd_half = bus.rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        load_data = bus.rdata;
        if (ld_byte) begin
            load_data = {{(DATA_WIDTH-8){ld_signed & rd_byte[7]}}, rd_byte};
        end else if (ld_half) begin
            load_data = {{(DATA_WIDTH-16){ld_signed & rd_half[15]}}, rd_half};
        end
    end

    // Upstream fields are held stable until the DONE handshake, so addresses/data are wired.
    assign bus.araddr  = {addr[DATA_WIDTH-1:2], 2'b00};
    assign bus.awaddr  = {addr[DATA_WIDTH-1:2], 2'b00};
    assign bus.wdata_o = wdata << {addr[1:0], 3'b000};
    assign bus.wstrb   = wmask << addr[1:0];

    assign in_ready  = ~in_valid | ((state_q == StDone) & out_ready);
    assign out_valid = (state_q == StDone);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if ((mem_read & mem_write) | misaligned) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (mem_read) begin
                        state_d = StRdAddr;
                    end else if (mem_write) begin
                        state_d = StWrReq;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRdAddr: begin
                bus.arvalid = 1'b1;
                if (bus.arready) state_d = StRdData;
            end
            StRdData: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    rdata_d = load_data;
                    err_d   = (bus.rresp != 2'b00);
                    state_d = StDone;
                end
            end
            StWrReq: begin
                // AW and W complete independently; leave once both have handshaken.
                bus.awvalid = ~aw_done_q;
                bus.wvalid  = ~w_done_q;
                aw_done_d   = aw_done_q | bus.awready;
                w_done_d    = w_done_q | bus.wready;
                if (aw_done_d & w_done_d) state_d = StWrResp;
            end
            StWrResp: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    rdata_d = '0;
                    err_d   = (bus.bresp != 2'b00);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed loads/stores against a simple bus slave model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [3:0]  wmask = 4'b0;
    logic [2:0]  ropcode = 3'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] wdata = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_rdata;
    logic        out_err;

    always #5 clk = ~clk;

    mem_stage_lsu_if bus ();

    mem_stage_lsu dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .wmask     (wmask),
        .ropcode   (ropcode),
        .addr      (addr),
        .wdata     (wdata),
        .bus       (bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_err   (out_err)
    );

    // Slave model: zero-wait except for a programmable AW stall.
    logic [31:0] s_rdata = 32'h80FF_1234;
    logic [1:0]  s_rresp = 2'b00;
    logic [1:0]  s_bresp = 2'b00;
    logic        s_rvalid_en = 1'b1;
    int          aw_delay = 0;
    int          aw_wait = 0;

    assign bus.arready = 1'b1;
    assign bus.rdata   = s_rdata;
    assign bus.rresp   = s_rresp;
    assign bus.rvalid  = s_rvalid_en;
    assign bus.awready = (aw_wait >= aw_delay);
    assign bus.wready  = 1'b1;
    assign bus.bvalid  = 1'b1;
    assign bus.bresp   = s_bresp;

    always @(posedge clk) begin
        if (bus.awvalid && !bus.awready) aw_wait <= aw_wait + 1;
        else if (!bus.awvalid)           aw_wait <= 0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];

    // Bus activity monitor and result scoreboard.
    int          ar_cyc = 0, aw_cyc = 0, w_cyc = 0, bad_bready = 0;
    logic [31:0] last_araddr = 32'b0, last_awaddr = 32'b0, last_wdata = 32'b0;
    logic [3:0]  last_wstrb = 4'b0;
    logic        prev_ov = 1'b0;
    int          rise_cyc = 0;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.arvalid) begin ar_cyc++; last_araddr = bus.araddr; end
            if (bus.awvalid) begin aw_cyc++; last_awaddr = bus.awaddr; end
            if (bus.wvalid) begin w_cyc++; last_wdata = bus.wdata_o; last_wstrb = bus.wstrb; end
            if (bus.bready && (bus.awvalid || bus.wvalid)) bad_bready++;
            if (out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got out_rdata=0x%08h, no result expected",
                             out_rdata);
                end else begin
                    m_e = sb.pop_front();
                    check({m_e.name, "_rdata"}, out_rdata, m_e.rdata);
                    check({m_e.name, "_err"}, 32'(out_err), 32'(m_e.err));
                    if (m_e.lat >= 0) check({m_e.name, "_lat"}, 32'(rise_cyc - m_e.issue),
                                            32'(m_e.lat));
                end
            end
        end
    end

    task automatic do_op(input string name, input logic rd, input logic wr,
                         input logic [3:0] mask, input logic [2:0] rop,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid  = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        wmask     = mask;
        ropcode   = rop;
        addr      = a;
        wdata     = wd;
        e.name = name; e.rdata = exp_d; e.err = exp_e; e.lat = lat; e.issue = cyc;
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 60);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        check({name, "_ov_at_in_ready"}, 32'(out_valid), 32'd1);
        if (!in_ready) begin
            sb.delete();
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    int   ar0, aw0, w0, bb0, n;
    exp_t re;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_valids_readies",
              {25'b0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
               out_valid, out_err}, 32'd0);
        check("reset_out_rdata", out_rdata, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;

        ar0 = ar_cyc; aw0 = aw_cyc;
        do_op("nop", 1'b0, 1'b0, 4'b0, 3'b000, 32'h0000_1234, 32'h5555_5555, 32'd0, 1'b0, 1);
        check("nop_no_ar", 32'(ar_cyc - ar0), 32'd0);
        check("nop_no_aw", 32'(aw_cyc - aw0), 32'd0);

        ar0 = ar_cyc;
        do_op("lb", 1'b1, 1'b0, 4'b0, 3'b000, 32'h8000_0003, 32'd0, 32'hFFFF_FF80, 1'b0, 3);
        check("lb_araddr", last_araddr, 32'h8000_0000);
        check("lb_ar_cycles", 32'(ar_cyc - ar0), 32'd1);
        do_op("lbu", 1'b1, 1'b0, 4'b0, 3'b100, 32'h8000_0003, 32'd0, 32'h0000_0080, 1'b0, 3);
        do_op("lh", 1'b1, 1'b0, 4'b0, 3'b001, 32'h8000_0002, 32'd0, 32'hFFFF_80FF, 1'b0, 3);
        do_op("lhu", 1'b1, 1'b0, 4'b0, 3'b101, 32'h8000_0002, 32'd0, 32'h0000_80FF, 1'b0, 3);
        do_op("lb1", 1'b1, 1'b0, 4'b0, 3'b000, 32'h8000_0001, 32'd0, 32'h0000_0012, 1'b0, 3);
        do_op("lw_op011", 1'b1, 1'b0, 4'b0, 3'b011, 32'h8000_0004, 32'd0, 32'h80FF_1234,
              1'b0, 3);
        check("lw_op011_araddr", last_araddr, 32'h8000_0004);

        do_op("sh", 1'b0, 1'b1, 4'b0011, 3'b000, 32'h8000_0002, 32'h0000_BEEF, 32'd0, 1'b0, 3);
        check("sh_awaddr", last_awaddr, 32'h8000_0000);
        check("sh_wdata", last_wdata, 32'hBEEF_0000);
        check("sh_wstrb", 32'(last_wstrb), 32'b1100);
        do_op("sb", 1'b0, 1'b1, 4'b0001, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'd0, 1'b0, 3);
        check("sb_wdata", last_wdata, 32'h0000_AB00);
        check("sb_wstrb", 32'(last_wstrb), 32'b0010);

        aw_delay = 3;
        aw0 = aw_cyc; w0 = w_cyc; bb0 = bad_bready;
        do_op("sw_slow", 1'b0, 1'b1, 4'b1111, 3'b000, 32'h8000_0008, 32'hCAFE_F00D, 32'd0,
              1'b0, 6);
        check("sw_slow_aw_cycles", 32'(aw_cyc - aw0), 32'd4);
        check("sw_slow_w_cycles", 32'(w_cyc - w0), 32'd1);
        check("sw_slow_early_bready", 32'(bad_bready - bb0), 32'd0);
        check("sw_slow_awaddr", last_awaddr, 32'h8000_0008);
        aw_delay = 0;

        ar0 = ar_cyc;
        do_op("lw_mis", 1'b1, 1'b0, 4'b0, 3'b010, 32'h8000_0001, 32'd0, 32'd0, 1'b1, 1);
        check("lw_mis_no_ar", 32'(ar_cyc - ar0), 32'd0);
        aw0 = aw_cyc;
        do_op("sw_mis", 1'b0, 1'b1, 4'b1111, 3'b000, 32'h8000_0002, 32'h1, 32'd0, 1'b1, 1);
        do_op("sh_mis", 1'b0, 1'b1, 4'b0011, 3'b000, 32'h8000_0001, 32'h1, 32'd0, 1'b1, 1);
        check("st_mis_no_aw", 32'(aw_cyc - aw0), 32'd0);
        ar0 = ar_cyc; aw0 = aw_cyc;
        do_op("rd_wr", 1'b1, 1'b1, 4'b1111, 3'b010, 32'h8000_0000, 32'h1, 32'd0, 1'b1, 1);
        check("rd_wr_no_bus", 32'(ar_cyc - ar0 + aw_cyc - aw0), 32'd0);

        s_rresp = 2'b10;
        do_op("lw_slverr", 1'b1, 1'b0, 4'b0, 3'b010, 32'h8000_0000, 32'd0, 32'h80FF_1234,
              1'b1, 3);
        s_rresp = 2'b00;
        s_bresp = 2'b10;
        do_op("sw_slverr", 1'b0, 1'b1, 4'b1111, 3'b000, 32'h8000_0000, 32'h1, 32'd0, 1'b1, 3);
        s_bresp = 2'b00;

        // Reset while waiting in RD_DATA, then stall the result in DONE.
        s_rvalid_en = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        re.name = "rst_lw"; re.rdata = 32'h80FF_1234; re.err = 1'b0; re.lat = -1; re.issue = 0;
        sb.push_back(re);
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; ropcode = 3'b010;
        addr = 32'h8000_0004;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rready && n < 20);
        check("rst_reach_rd_data", 32'(bus.rready), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_bus_idle",
              {25'b0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
               out_valid, out_err}, 32'd0);
        check("rst_out_rdata", out_rdata, 32'd0);
        resetn = 1'b1;
        s_rvalid_en = 1'b1;
        @(negedge clk);
        check("rst_restart_from_idle", 32'(bus.arvalid), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 4; k++) begin
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_rdata", out_rdata, 32'h80FF_1234);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mem_read = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
